spell_mem_arbiter: RTL

Two-port arbiter that shares the single spell memory port (code/data SRAM, DFF memory and I/O window) between the spell core and the host/debug loader. Each requester presents a level request held until its completion pulse. The arbiter grants one requester at a time with round-robin fairness and forwards that requester's fields to the memory. It returns read data and a one-cycle ready pulse to the owner, and it aborts transactions that the memory never acknowledges.

---
 rtl/spell_mem_arbiter_pkg.sv | 21 ++
 rtl/spell_mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/spell_mem_arbiter_pkg.sv
// Shared definitions for the spell memory-port arbiter: FSM states, owner
// encoding, abort fill value and the memory-type select codes.
package spell_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SPELL_ARB_IDLE    = 2'd0,
    SPELL_ARB_BUSY    = 2'd1,
    SPELL_ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

  localparam logic [1:0] MEM_TYPE_CODE = 2'd0;
  localparam logic [1:0] MEM_TYPE_DATA = 2'd1;
  localparam logic [1:0] MEM_TYPE_DFF  = 2'd2;
  localparam logic [1:0] MEM_TYPE_IO   = 2'd3;

endpackage

// File: rtl/spell_mem_arbiter.sv
// Round-robin arbiter sharing the spell memory port between the spell core
// and the host/debug loader, with a busy-cycle watchdog that aborts stuck accesses.
module spell_mem_arbiter
  import spell_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       core_select,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_data_in,
  input  logic [1:0] core_memory_type,
  input  logic       core_write,
  output logic [7:0] core_data_out,
  output logic       core_data_ready,
  input  logic       host_select,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_data_in,
  input  logic [1:0] host_memory_type,
  input  logic       host_write,
  output logic [7:0] host_data_out,
  output logic       host_data_ready,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic [1:0] mem_memory_type,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,
  output logic       timeout
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_last_owner;
  logic       r_fields_live;
  logic [7:0] r_count;
  logic [7:0] r_core_data_out;
  logic [7:0] r_host_data_out;
  logic       r_core_data_ready;
  logic       r_host_data_ready;
  logic       r_timeout;

  logic       w_mux_owner;
  logic       w_owner_select;

  // Outside BUSY the fields follow last_owner; they stay zero until the first grant.
  assign w_mux_owner    = (r_state == SPELL_ARB_BUSY) ? r_owner : r_last_owner;
  assign w_owner_select = (r_owner == OWNER_HOST) ? host_select : core_select;

  assign mem_select      = (r_state == SPELL_ARB_BUSY);
  assign mem_addr        = !r_fields_live ? '0 :
                           (w_mux_owner == OWNER_HOST) ? host_addr : core_addr;
  assign mem_data_in     = !r_fields_live ? '0 :
                           (w_mux_owner == OWNER_HOST) ? host_data_in : core_data_in;
  assign mem_memory_type = !r_fields_live ? '0 :
                           (w_mux_owner == OWNER_HOST) ? host_memory_type : core_memory_type;
  assign mem_write       = r_fields_live &&
                           ((w_mux_owner == OWNER_HOST) ? host_write : core_write);

  assign core_data_out   = r_core_data_out;
  assign host_data_out   = r_host_data_out;
  assign core_data_ready = r_core_data_ready;
  assign host_data_ready = r_host_data_ready;
  assign timeout         = r_timeout;

  // NOTE: every state register uses non-blocking assignment so all updates in
  // this block see the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= SPELL_ARB_IDLE;
      r_owner           <= OWNER_CORE;
      r_last_owner      <= OWNER_HOST;
      r_fields_live     <= 1'b0;
      r_count           <= '0;
      r_core_data_out   <= '0;
      r_host_data_out   <= '0;
      r_core_data_ready <= 1'b0;
      r_host_data_ready <= 1'b0;
      r_timeout         <= 1'b0;
    end else begin
      r_core_data_ready <= 1'b0;
      r_host_data_ready <= 1'b0;
      r_timeout         <= 1'b0;
      case (r_state)
        SPELL_ARB_IDLE: begin
          // On a tie the requester that did not complete last wins.
          if (core_select && (!host_select || r_last_owner == OWNER_HOST)) begin
            r_owner       <= OWNER_CORE;
            r_count       <= '0;
            r_fields_live <= 1'b1;
            r_state       <= SPELL_ARB_BUSY;
          end else if (host_select) begin
            r_owner       <= OWNER_HOST;
            r_count       <= '0;
            r_fields_live <= 1'b1;
            r_state       <= SPELL_ARB_BUSY;
          end
        end
        SPELL_ARB_BUSY: begin
          if (!w_owner_select) begin
            r_state <= SPELL_ARB_RELEASE;
          end else if (mem_data_ready) begin
            if (r_owner == OWNER_HOST) begin
              r_host_data_out   <= mem_data_out;
              r_host_data_ready <= 1'b1;
            end else begin
              r_core_data_out   <= mem_data_out;
              r_core_data_ready <= 1'b1;
            end
            r_last_owner <= r_owner;
            r_state      <= SPELL_ARB_RELEASE;
          end else if (r_count == TIMEOUT_LAST) begin
            if (r_owner == OWNER_HOST) begin
              r_host_data_out   <= TIMEOUT_FILL;
              r_host_data_ready <= 1'b1;
            end else begin
              r_core_data_out   <= TIMEOUT_FILL;
              r_core_data_ready <= 1'b1;
            end
            r_timeout <= 1'b1;
            r_state   <= SPELL_ARB_RELEASE;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        SPELL_ARB_RELEASE: r_state <= SPELL_ARB_IDLE;
        default:           r_state <= SPELL_ARB_IDLE;
      endcase
    end
  end

endmodule
